// File: rtl/gpu_pkg.sv
// Shared constants and types for the display GPU: VGA timing defaults,
// framebuffer geometry, RGB444 pixel format and render-FSM states.
package gpu_pkg;
    localparam int DFLT_CLK_DIV  = 2;
    localparam int DFLT_H_ACTIVE = 640;
    localparam int DFLT_H_FP     = 16;
    localparam int DFLT_H_SYNC   = 96;
    localparam int DFLT_H_BP     = 48;
    localparam int DFLT_V_ACTIVE = 480;
    localparam int DFLT_V_FP     = 10;
    localparam int DFLT_V_SYNC   = 2;
    localparam int DFLT_V_BP     = 33;

    localparam int FB_W     = 80;
    localparam int FB_H     = 60;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = $clog2(FB_DEPTH);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DRAW  = 2'd2
    } render_state_t;

    function automatic logic [7:0] expand4(input logic [3:0] n);
        return {n, n};
    endfunction
endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-clock divider, h/v counters, sync/active decode and
// a one-tick pulse on the tick where the raster enters vertical blanking.
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       srst,
    output logic       tick,
    output logic       vga_clk,
    output logic [6:0] col,
    output logic [6:0] row,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active,
    output logic       vblank_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_reg;
    logic [DW-1:0] div_next;
    logic          vga_clk_reg;
    logic [9:0]    h_cnt_reg;
    logic [9:0]    v_cnt_reg;

    assign tick     = (div_reg == DW'(CLK_DIV - 1));
    assign div_next = tick ? '0 : div_reg + DW'(1);

    // vga_clk is high for the first half of each divider period, so it rises on the tick
    always_ff @(posedge clk) begin
        if (srst) begin
            div_reg     <= '0;
            vga_clk_reg <= 1'b0;
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
        end else begin
            div_reg     <= div_next;
            vga_clk_reg <= (div_next < DW'(CLK_DIV / 2));
            if (tick) begin
                if (h_cnt_reg == H_LAST) begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
                end else begin
                    h_cnt_reg <= h_cnt_reg + 10'd1;
                end
            end
        end
    end

    assign vga_clk      = vga_clk_reg;
    assign col          = h_cnt_reg[9:3];
    assign row          = v_cnt_reg[9:3];
    assign hsync_n      = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
    assign vsync_n      = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
    assign active       = (h_cnt_reg < 10'(H_ACTIVE)) && (v_cnt_reg < 10'(V_ACTIVE));
    assign vblank_start = tick && (h_cnt_reg == H_LAST) && (v_cnt_reg == 10'(V_ACTIVE - 1));
endmodule

// File: rtl/gpu_top.sv
// Display GPU top: render FSM filling an 80x60 RGB444 framebuffer plus an 8x
// upscaling VGA scan-out. Define GPU_TEST_PATTERN_EN to scan out colour bars instead.
module gpu_top
    import gpu_pkg::*;
#(
    parameter int CLK_DIV  = DFLT_CLK_DIV,
    parameter int H_ACTIVE = DFLT_H_ACTIVE,
    parameter int H_FP     = DFLT_H_FP,
    parameter int H_SYNC   = DFLT_H_SYNC,
    parameter int H_BP     = DFLT_H_BP,
    parameter int V_ACTIVE = DFLT_V_ACTIVE,
    parameter int V_FP     = DFLT_V_FP,
    parameter int V_SYNC   = DFLT_V_SYNC,
    parameter int V_BP     = DFLT_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       vga_clk,
    output logic [7:0] red_vga,
    output logic [7:0] green_vga,
    output logic [7:0] blue_vga,
    output logic       h_sync,
    output logic       v_sync,
    output logic       blank_n,
    output logic       sync_n
);
    logic       tick;
    logic       hsync_n;
    logic       vsync_n;
    logic       active;
    logic       vblank_start;
    logic [6:0] col;
    logic [6:0] row;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk         (clk),
        .srst        (reset),
        .tick        (tick),
        .vga_clk     (vga_clk),
        .col         (col),
        .row         (row),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .active      (active),
        .vblank_start(vblank_start)
    );

    render_state_t    state_reg;
    render_state_t    state_next;
    logic [FB_AW-1:0] wr_addr_reg;
    logic [6:0]       x_reg;
    logic [5:0]       y_reg;
    logic [3:0]       f_reg;
    logic [7:0]       frame_reg;
    logic             wr_en;
    logic             last_addr;
    rgb444_t          wr_data;

    assign last_addr = (wr_addr_reg == FB_AW'(FB_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state_reg <= CLEAR;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR:   if (last_addr)    state_next = IDLE;
            IDLE:    if (vblank_start) state_next = DRAW;
            DRAW:    if (last_addr)    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_reg)
            CLEAR: wr_en = 1'b1;
            DRAW: begin
                wr_en     = 1'b1;
                wr_data.r = x_reg[3:0] + f_reg;
                wr_data.g = y_reg[3:0];
                wr_data.b = x_reg[3:0] ^ y_reg[3:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            f_reg       <= '0;
            frame_reg   <= '0;
        end else begin
            if (vblank_start) frame_reg <= frame_reg + 8'd1;
            // frame_reg updates on this same edge, so latch its incremented value
            if (state_reg == IDLE && vblank_start) f_reg <= frame_reg[3:0] + 4'd1;
            if (wr_en) begin
                if (last_addr) begin
                    wr_addr_reg <= '0;
                    x_reg       <= '0;
                    y_reg       <= '0;
                end else begin
                    wr_addr_reg <= wr_addr_reg + FB_AW'(1);
                    if (x_reg == 7'(FB_W - 1)) begin
                        x_reg <= '0;
                        y_reg <= y_reg + 6'd1;
                    end else begin
                        x_reg <= x_reg + 7'd1;
                    end
                end
            end
        end
    end

    rgb444_t          fb_mem [FB_DEPTH];
    rgb444_t          rd_data_reg;
    logic [FB_AW-1:0] rd_addr;

    assign rd_addr = active ? (FB_AW'(row) * FB_AW'(FB_W) + FB_AW'(col)) : '0;

    // read-before-write: a same-address collision returns the previous contents
    always_ff @(posedge clk) begin
        if (wr_en) fb_mem[wr_addr_reg] <= wr_data;
        if (tick)  rd_data_reg <= fb_mem[rd_addr];
    end

    logic [23:0] pix_rgb;
`ifdef GPU_TEST_PATTERN_EN
    logic [2:0] bar_reg;

    // 80-pixel bars: h/80 == (h>>3)/10
    always_ff @(posedge clk) begin
        if (tick) bar_reg <= 3'(col / 7'd10);
    end
    assign pix_rgb = {{8{bar_reg[2]}}, {8{bar_reg[1]}}, {8{bar_reg[0]}}};
`else
    assign pix_rgb = {expand4(rd_data_reg.r), expand4(rd_data_reg.g), expand4(rd_data_reg.b)};
`endif

    logic       hs1_reg;
    logic       vs1_reg;
    logic       act1_reg;
    logic       h_sync_reg;
    logic       v_sync_reg;
    logic       blank_n_reg;
    logic [7:0] red_reg;
    logic [7:0] green_reg;
    logic [7:0] blue_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs1_reg     <= 1'b1;
            vs1_reg     <= 1'b1;
            act1_reg    <= 1'b0;
            h_sync_reg  <= 1'b1;
            v_sync_reg  <= 1'b1;
            blank_n_reg <= 1'b0;
            red_reg     <= '0;
            green_reg   <= '0;
            blue_reg    <= '0;
        end else if (tick) begin
            hs1_reg     <= hsync_n;
            vs1_reg     <= vsync_n;
            act1_reg    <= active;
            h_sync_reg  <= hs1_reg;
            v_sync_reg  <= vs1_reg;
            blank_n_reg <= act1_reg;
            {red_reg, green_reg, blue_reg} <= act1_reg ? pix_rgb : 24'h0;
        end
    end

    assign red_vga   = red_reg;
    assign green_vga = green_reg;
    assign blue_vga  = blue_reg;
    assign h_sync    = h_sync_reg;
    assign v_sync    = v_sync_reg;
    assign blank_n   = blank_n_reg;
    assign sync_n    = 1'b0;
endmodule

// File: tb/tb_gpu_top.sv
// Directed bench for gpu_top: a default-timing instance for horizontal timing and
// a reduced-vertical/horizontal instance for frame-level rendering and mid-DRAW reset.
module tb_gpu_top;
    import gpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_d;
    logic       reset_s;

    logic       vga_clk_d, h_sync_d, v_sync_d, blank_n_d, sync_n_d;
    logic [7:0] red_d, green_d, blue_d;
    logic       vga_clk_s, h_sync_s, v_sync_s, blank_n_s, sync_n_s;
    logic [7:0] red_s, green_s, blue_s;
    logic [23:0] rgb_d, rgb_s;

    assign rgb_d = {red_d, green_d, blue_d};
    assign rgb_s = {red_s, green_s, blue_s};

    always #5 clk = ~clk;

    gpu_top u_dut_d (
        .clk(clk), .reset(reset_d), .vga_clk(vga_clk_d),
        .red_vga(red_d), .green_vga(green_d), .blue_vga(blue_d),
        .h_sync(h_sync_d), .v_sync(v_sync_d), .blank_n(blank_n_d), .sync_n(sync_n_d)
    );

    // line = 200 ticks (hsync 168..183), frame = 38 lines (vsync 26..27, vblank from 24)
    gpu_top #(
        .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(16),
        .V_ACTIVE(24),  .V_FP(2), .V_SYNC(2),  .V_BP(10)
    ) u_dut_s (
        .clk(clk), .reset(reset_s), .vga_clk(vga_clk_s),
        .red_vga(red_s), .green_vga(green_s), .blue_vga(blue_s),
        .h_sync(h_sync_s), .v_sync(v_sync_s), .blank_n(blank_n_s), .sync_n(sync_n_s)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    localparam int RST_POS = 41000;
    localparam int P_END   = RST_POS + 1 + 6420 + 8;

    int   hs_fall1 = -1, hs_rise1 = -1, hs_fall2 = -1;
    int   blank_d_cnt = 0, blank_d_first = -1;
    int   vs_fall_s = -1, vs_low_s = 0, blank_s_cnt = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    logic rgb_d_nz = 1'b0, sync_n_seen = 1'b0;

    // Output for counter value C is valid from edge 2*(C+2) after reset release.
    initial begin
        reset_d = 1'b1;
        reset_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_d = 1'b0;
        reset_s = 1'b0;

        check("rst_vga_clk", 32'(vga_clk_d), 32'd0);
        check("rst_h_sync",  32'(h_sync_d),  32'd1);
        check("rst_v_sync",  32'(v_sync_d),  32'd1);
        check("rst_blank_n", 32'(blank_n_d), 32'd0);
        check("rst_sync_n",  32'(sync_n_d),  32'd0);
        check("rst_rgb",     32'(rgb_d),     32'h0);

        for (int pos = 1; pos <= P_END; pos++) begin
            @(posedge clk);
            @(negedge clk);

            if (sync_n_d || sync_n_s) sync_n_seen = 1'b1;
            if (pos <= 6) check($sformatf("vga_clk_e%0d", pos), 32'(vga_clk_d), 32'((pos % 2) == 0));

            if (pos <= 3200) begin
                if (hs_prev && !h_sync_d) begin
                    if (hs_fall1 < 0) hs_fall1 = pos;
                    else if (hs_fall2 < 0) hs_fall2 = pos;
                end
                if (!hs_prev && h_sync_d && hs_rise1 < 0) hs_rise1 = pos;
                hs_prev = h_sync_d;
            end
            if (pos <= 1600 && blank_n_d) begin
                blank_d_cnt++;
                if (blank_d_first < 0) blank_d_first = pos;
            end
            if (pos <= 15203) begin
                if (vs_prev && !v_sync_s && vs_fall_s < 0) vs_fall_s = pos;
                vs_prev = v_sync_s;
                if (!v_sync_s) vs_low_s++;
                if (blank_n_s) blank_s_cnt++;
            end

`ifdef GPU_TEST_PATTERN_EN
            if (pos == 4)    check("bar0_h0",   32'(rgb_d), 32'h000000);
            if (pos == 204)  check("bar1_h100", 32'(rgb_d), 32'h0000FF);
            if (pos == 504)  check("bar3_h250", 32'(rgb_d), 32'h00FFFF);
            if (pos == 1204) check("bar7_h600", 32'(rgb_d), 32'hFFFFFF);
`else
            if (pos <= 1600 && rgb_d != 24'h0) rgb_d_nz = 1'b1;
            if (pos == 6420) begin
                check("f0_px8_16_rgb",   32'(rgb_s),     32'h000000);
                check("f0_px8_16_blank", 32'(blank_n_s), 32'd1);
            end
            if (pos == 15204) check("f1_px0_0",     32'(rgb_s), 32'h110000);
            if (pos == 15444) check("f1_px120_0",   32'(rgb_s), 32'h0000FF);
            if (pos == 21620) check("f1_px8_16",    32'(rgb_s), 32'h222233);
            if (pos == 21944) begin
                check("f1_hblank_rgb",   32'(rgb_s),     32'h000000);
                check("f1_hblank_blank", 32'(blank_n_s), 32'd0);
            end
            if (pos == 24722) check("f1_px159_23",  32'(rgb_s), 32'h442211);
            if (pos == 36820) check("f2_px8_16",    32'(rgb_s), 32'h332233);
`endif

            if (pos == RST_POS) begin
                check("pre_rst_state", 32'(u_dut_s.state_reg), 32'(DRAW));
                check("pre_rst_frame", 32'(u_dut_s.frame_reg), 32'd3);
                reset_s = 1'b1;
            end
            if (pos == RST_POS + 1) begin
                reset_s = 1'b0;
                check("mid_rst_vga_clk", 32'(vga_clk_s), 32'd0);
                check("mid_rst_rgb",     32'(rgb_s),     32'h0);
                check("mid_rst_h_sync",  32'(h_sync_s),  32'd1);
                check("mid_rst_v_sync",  32'(v_sync_s),  32'd1);
                check("mid_rst_blank_n", 32'(blank_n_s), 32'd0);
                check("mid_rst_state",   32'(u_dut_s.state_reg),   32'(CLEAR));
                check("mid_rst_frame",   32'(u_dut_s.frame_reg),   32'd0);
                check("mid_rst_addr",    32'(u_dut_s.wr_addr_reg), 32'd0);
            end
            if (pos == RST_POS + 1 + 6420) check("post_rst_px8_16", 32'(rgb_s), 32'h000000);
        end

        check("hsync_first_fall_edge", 32'(hs_fall1), 32'd1316);
        check("hsync_low_edges",       32'(hs_rise1 - hs_fall1), 32'd192);
        check("hsync_period_edges",    32'(hs_fall2 - hs_fall1), 32'd1600);
        check("blank_line0_first",     32'(blank_d_first), 32'd4);
        check("blank_line0_edges",     32'(blank_d_cnt),   32'd1280);
        check("vsync_s_first_fall",    32'(vs_fall_s),     32'd10404);
        check("vsync_s_low_edges",     32'(vs_low_s),      32'd800);
        check("blank_s_frame0_edges",  32'(blank_s_cnt),   32'd7680);
        check("sync_n_always_low",     32'(sync_n_seen),   32'd0);
`ifndef GPU_TEST_PATTERN_EN
        check("line0_rgb_all_zero",    32'(rgb_d_nz),      32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/gpu_top.md
Name: gpu_top

Overview:
- Minimal display GPU: a render engine procedurally fills an 80x60 RGB444 framebuffer.
- A VGA scan-out path upscales the framebuffer 8x to 640x480@60 and drives a DAC-style VGA interface (8-bit R/G/B, syncs, blank_n, sync_n).
- Top-level block of the GPU subsystem; no host bus, self-running after reset.

Parameters:
- CLK_DIV, 2, system clocks per vga_clk period (even, >=2).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (line = 800).
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (frame = 525).
- FB_W/FB_H, 80/60, framebuffer size; scale = 8.

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- vga_clk  out  1  pixel clock, clk/CLK_DIV, 50% duty.
- red_vga  out  8  red channel.
- green_vga  out  8  green channel.
- blue_vga  out  8  blue channel.
- h_sync  out  1  horizontal sync, active low.
- v_sync  out  1  vertical sync, active low.
- blank_n  out  1  high only during active video.
- sync_n  out  1  composite sync to DAC; constant 0.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: vga_clk=0, R/G/B=0, h_sync=1, v_sync=1, blank_n=0, sync_n=0, h_cnt=v_cnt=0, frame=0, render state=CLEAR, address=0.
- Pixel tick: one-clk enable, asserted when the divider wraps. vga_clk rises on the tick.
- h_cnt 0..799 advances per tick. v_cnt 0..524 advances when h_cnt wraps.
- h_sync low for h_cnt in [656,751]. v_sync low for v_cnt in [490,491]. Active region: h_cnt<640 and v_cnt<480.
- Scan-out:
  - FB read address = (v_cnt>>3)*80 + (h_cnt>>3).
  - Framebuffer read is synchronous.
  - RGB, h_sync, v_sync and blank_n are all delayed 2 ticks from the counters, so they stay aligned.
  - Each RGB444 nibble is replicated to 8 bits ({n,n}).
  - RGB is forced to 0 when delayed blank_n=0.
- frame (8-bit) increments on the tick where v_cnt becomes 480 with h_cnt=0; wraps 255->0.
- Render FSM states:
  - CLEAR: writes 0x000 to addresses 0..4799, one per clk, then goes to IDLE.
  - IDLE: waits for the vblank-start tick (same event as the frame increment).
  - DRAW: latches frame as f, writes addresses 0..4799 one per clk, then returns to IDLE.
  - DRAW colour for x=addr%80, y=addr/80: R=x[3:0]+f[3:0] (mod 16), G=y[3:0], B=(x^y)[3:0]. Keep x,y as counters; no divider.
  - A vblank event during CLEAR or DRAW is ignored.
- Framebuffer: 4800x12 simple dual-port (1 write, 1 read). On a same-address collision the read returns the old data.
- Reset mid-frame or mid-DRAW: all state returns to reset values and CLEAR restarts. Framebuffer contents are not reset and are overwritten by CLEAR.

Optional Feature:
- GPU_TEST_PATTERN_EN defined: scan-out bypasses the framebuffer and shows 8 vertical colour bars, each 80 px wide. Bar index i=h_cnt[9:7]... use h_cnt/80. Colour R=i[2]?FF:00, G=i[1]?FF:00, B=i[0]?FF:00, same 2-tick latency. Render FSM still runs.
- Not defined: normal framebuffer scan-out.

Decomposition:
- gpu_pkg: timing constants, FB_W/FB_H/FB_DEPTH, rgb444 typedef, render-state enum.
- Sub-module vga_timing: divider, h/v counters, sync/active flags, vblank-start pulse.
- Render FSM and framebuffer stay in gpu_top.

Test Plan:
- Reset held 1 clk then released -> sync_n=0 always. vga_clk toggles every clk (period 2 clks). h_sync=1, v_sync=1 at release.
- Count ticks from reset -> first h_sync fall 658 ticks after release (656+2 latency), low for exactly 96 ticks, period 800 ticks.
- Run >525 lines -> v_sync low for exactly 2 lines (1600 ticks) starting at line 490 (+2 ticks). blank_n high 640 ticks per line, only on lines 0..479.
- Frame 0 → frame 1 scan of pixel (h=8,v=16), FB addr 161, x=1, y=2 -> R=0x22 (x+f=1+1), G=0x22, B=0x33.
- First frame after reset (CLEAR done, before first DRAW) -> all active RGB = 0; blanking RGB = 0 always.
- Assert reset mid-DRAW -> next clk outputs at reset values, FSM in CLEAR, frame=0. Compile with GPU_TEST_PATTERN_EN -> h_cnt 80..159 gives R=00,G=00,B=FF.
